// File: rtl/neopixel_frame_ctrl.sv
// neopixel_frame_ctrl
// Frame sequencer for a WS2812 one-wire LED chain. Holds a NUM_PIXELS x 24-bit
// GRB pixel store written from the bus side. On a start request it shifts every
// pixel out MSB-first with fixed bit timing, then holds the line low for the
// latch gap and pulses o_frame_done.
// Optional feature macro: NEOPIXEL_AUTO_REFRESH_EN adds the i_refresh_en port
// and a free-running refresh timer that issues start requests on its own.
module neopixel_frame_ctrl #(
   parameter int NUM_PIXELS     = 8,
   parameter int T0H_CYCLES     = 20,
   parameter int T1H_CYCLES     = 40,
   parameter int T_BIT_CYCLES   = 63,
   parameter int T_LATCH_CYCLES = 2500,
`ifdef NEOPIXEL_AUTO_REFRESH_EN
   parameter int REFRESH_CYCLES = 833333,
`endif
   localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [23:0]   i_wr_data,
   input  logic          i_start,
`ifdef NEOPIXEL_AUTO_REFRESH_EN
   input  logic          i_refresh_en,
`endif
   output logic          o_busy,
   output logic          o_frame_done,
   output logic          o_one_wire
);

   // One counter serves both the bit period and the latch gap.
   localparam int CNT_MAX = (T_BIT_CYCLES > T_LATCH_CYCLES) ? T_BIT_CYCLES : T_LATCH_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] C_T0H_LAST   = CW'(T0H_CYCLES - 1);
   localparam logic [CW-1:0] C_T1H_LAST   = CW'(T1H_CYCLES - 1);
   localparam logic [CW-1:0] C_BIT_LAST   = CW'(T_BIT_CYCLES - 1);
   localparam logic [CW-1:0] C_LATCH_LAST = CW'(T_LATCH_CYCLES - 1);
   localparam logic [AW-1:0] C_PIX_LAST   = AW'(NUM_PIXELS - 1);
   localparam logic [AW:0]   C_NUM_PIX    = (AW + 1)'(NUM_PIXELS);
   localparam logic [4:0]    C_MSB_IDX    = 5'd23;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_BIT_HI,
      S_BIT_LO,
      S_LATCH
   } state_t;

   state_t        r_state;
   state_t        w_state_next;

   logic [23:0]   r_pixel_mem [NUM_PIXELS];
   logic [23:0]   r_shift;
   logic [CW-1:0] r_cnt;
   logic [4:0]    r_bit_cnt;
   logic [AW-1:0] r_pix;
   logic          r_pending;
   logic          r_busy;
   logic          r_frame_done;
   logic          r_one_wire;

   logic          w_req;
   logic          w_refresh_tick;
   logic          w_hi_end;
   logic          w_bit_end;
   logic          w_latch_end;
   logic          w_last_bit;
   logic          w_last_pix;
   logic          w_frame_start;
   logic          w_fetch;
   logic [AW-1:0] w_fetch_addr;

   assign w_req       = i_start | w_refresh_tick;
   assign w_hi_end    = (r_cnt == (r_shift[23] ? C_T1H_LAST : C_T0H_LAST));
   assign w_bit_end   = (r_cnt == C_BIT_LAST);
   assign w_latch_end = (r_cnt == C_LATCH_LAST);
   assign w_last_bit  = (r_bit_cnt == 5'd0);
   assign w_last_pix  = (r_pix == C_PIX_LAST);

   // Pixel store write port; out-of-range addresses are dropped.
   always_ff @(posedge i_clock) begin
      if (i_wr_en && ({1'b0, i_wr_addr} < C_NUM_PIX)) begin
         r_pixel_mem[i_wr_addr] <= i_wr_data;
      end
   end

`ifdef NEOPIXEL_AUTO_REFRESH_EN
   localparam int RW = $clog2(REFRESH_CYCLES + 1);
   localparam logic [RW-1:0] C_REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

   logic [RW-1:0] r_refresh_cnt;

   assign w_refresh_tick = i_refresh_en && (r_refresh_cnt == C_REFRESH_LAST);

   // Refresh timer: counts start-to-start, restarts whenever a frame begins.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_refresh_cnt <= '0;
      end else if (!i_refresh_en) begin
         r_refresh_cnt <= '0;
      end else if (w_frame_start || w_refresh_tick) begin
         r_refresh_cnt <= '0;
      end else begin
         r_refresh_cnt <= r_refresh_cnt + RW'(1);
      end
   end
`else
   assign w_refresh_tick = 1'b0;
`endif

   // Next-state and fetch control for the frame sequencer.
   always_comb begin
      w_state_next  = r_state;
      w_frame_start = 1'b0;
      w_fetch       = 1'b0;
      w_fetch_addr  = r_pix + AW'(1);
      case (r_state)
         S_IDLE: begin
            if (w_req || r_pending) begin
               w_state_next  = S_LOAD;
               w_frame_start = 1'b1;
            end
         end
         S_LOAD: begin
            w_state_next = S_BIT_HI;
            w_fetch      = 1'b1;
            w_fetch_addr = '0;
         end
         S_BIT_HI: begin
            if (w_hi_end) begin
               w_state_next = S_BIT_LO;
            end
         end
         S_BIT_LO: begin
            if (w_bit_end) begin
               if (w_last_bit && w_last_pix) begin
                  w_state_next = S_LATCH;
               end else begin
                  w_state_next = S_BIT_HI;
                  // The next pixel is latched on the final cycle of bit 0.
                  w_fetch      = w_last_bit;
               end
            end
         end
         S_LATCH: begin
            if (w_latch_end) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Timing counter, bit/pixel indices and the pixel shift register.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_cnt     <= '0;
         r_bit_cnt <= '0;
         r_pix     <= '0;
         r_shift   <= '0;
      end else begin
         case (r_state)
            S_LOAD: begin
               r_cnt     <= '0;
               r_bit_cnt <= C_MSB_IDX;
               r_pix     <= '0;
            end
            S_BIT_HI: begin
               r_cnt <= r_cnt + CW'(1);
            end
            S_BIT_LO: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (w_last_bit) begin
                     r_bit_cnt <= C_MSB_IDX;
                     if (!w_last_pix) begin
                        r_pix <= r_pix + AW'(1);
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt - 5'd1;
                     r_shift   <= {r_shift[22:0], 1'b0};
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_LATCH: begin
               if (w_latch_end) begin
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
         // Registered read of the store; a same-cycle write is not seen here.
         if (w_fetch) begin
            r_shift <= r_pixel_mem[w_fetch_addr];
         end
      end
   end

   // Requests arriving mid-frame collapse into a single pending frame.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_pending <= 1'b0;
      end else if (w_frame_start) begin
         r_pending <= 1'b0;
      end else if (w_req && (r_state != S_IDLE)) begin
         r_pending <= 1'b1;
      end
   end

   // Outputs are registered from the next state so the line never glitches.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_one_wire   <= 1'b0;
      end else begin
         r_busy       <= (w_state_next != S_IDLE);
         r_frame_done <= (r_state == S_LATCH) && w_latch_end;
         r_one_wire   <= (w_state_next == S_BIT_HI);
      end
   end

   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;
   assign o_one_wire   = r_one_wire;

endmodule
